// File: rtl/host_link_seq.sv
// Host-side link sequencer: holds the core in reset, streams a program image over 8N1 UART,
// releases reset after a hold, then captures returned bytes into a FIFO. Optional header: HOST_LINK_LEN_HDR_EN.
module host_link_seq #(
  parameter int CLK_PER_HALF_BIT = 100,
  parameter int DATA_BYTES       = 4,
  parameter int ADDR_W           = 8,
  parameter int RX_DEPTH         = 16,
  parameter int RESET_HOLD       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W:0]         word_count,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    txd,
  input  logic                    rxd,
  output logic                    core_rst,
  output logic                    busy,
  output logic                    running,
  output logic                    rx_valid,
  output logic [7:0]              rx_data,
  input  logic                    rx_ready,
  output logic                    rx_overflow,
  output logic                    frame_err
);
  localparam int WORD_W = 8*DATA_BYTES;
  localparam int CYC_W  = $clog2(2*CLK_PER_HALF_BIT);
  localparam int BYTE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int PTR_W  = $clog2(RX_DEPTH);
  localparam logic [CYC_W-1:0]  BIT_LAST  = CYC_W'(2*CLK_PER_HALF_BIT - 1);
  localparam logic [CYC_W-1:0]  HALF_LAST = CYC_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(DATA_BYTES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [PTR_W:0]    DEPTH     = (PTR_W+1)'(RX_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_RELEASE, S_RUN} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  state_t              state, state_next;
  logic                fetch_wait, tx_on;
  logic [CYC_W-1:0]    tx_cyc;
  logic [3:0]          tx_bit;
  logic [BYTE_W-1:0]   tx_byte;
  logic [WORD_W-1:0]   tx_word, load_src;
  logic [ADDR_W:0]     words_left;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                in_tx, bit_end, frame_end, word_end, first_load, more, load_word, src_hdr, from_mem;

  assign in_tx      = (state == S_HDR) || (state == S_LOAD);
  assign bit_end    = tx_on && (tx_cyc == BIT_LAST);
  assign frame_end  = bit_end && (tx_bit == 4'd9);
  assign word_end   = frame_end && (tx_byte == BYTE_LAST);
  assign first_load = in_tx && !tx_on && !fetch_wait;
  assign more       = |words_left;
  assign load_word  = first_load || (word_end && more);
  assign from_mem   = load_word && !src_hdr;

`ifdef HOST_LINK_LEN_HDR_EN
  // The header word is the sampled count, which words_left still holds until the first memory load.
  assign src_hdr  = (state == S_HDR) && first_load;
  assign load_src = src_hdr ? WORD_W'(words_left) : rd_data;
`else
  assign src_hdr  = 1'b0;
  assign load_src = rd_data;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef HOST_LINK_LEN_HDR_EN
          state_next = S_HDR;
`else
          if (~|word_count) state_next = S_RELEASE;
          else              state_next = S_LOAD;
`endif
        end else begin
          state_next = S_IDLE;
        end
      end
      S_HDR: begin
        if (word_end) state_next = more ? S_LOAD : S_RELEASE;
        else          state_next = S_HDR;
      end
      S_LOAD: begin
        if (word_end && !more) state_next = S_RELEASE;
        else                   state_next = S_LOAD;
      end
      S_RELEASE: begin
        if (hold_cnt == HOLD_LAST) state_next = S_RUN;
        else                       state_next = S_RELEASE;
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      running  <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      state    <= state_next;
      busy     <= (state_next == S_HDR) || (state_next == S_LOAD) || (state_next == S_RELEASE);
      running  <= (state_next == S_RUN);
      core_rst <= (state_next != S_RUN);
    end
  end

  // The next word is fetched as soon as the current one is loaded, so it is ready at the word boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_wait <= 1'b0;
      tx_on      <= 1'b0;
      tx_cyc     <= {CYC_W{1'b0}};
      tx_bit     <= 4'd0;
      tx_byte    <= {BYTE_W{1'b0}};
      tx_word    <= {WORD_W{1'b0}};
      words_left <= {(ADDR_W+1){1'b0}};
      rd_addr    <= {ADDR_W{1'b0}};
      hold_cnt   <= {HOLD_W{1'b0}};
      txd        <= 1'b1;
    end else if ((state == S_IDLE) && start) begin
      fetch_wait <= 1'b1;
      rd_addr    <= {ADDR_W{1'b0}};
      words_left <= word_count;
      hold_cnt   <= {HOLD_W{1'b0}};
    end else if (load_word) begin
      fetch_wait <= 1'b0;
      tx_on      <= 1'b1;
      tx_word    <= load_src;
      tx_cyc     <= {CYC_W{1'b0}};
      tx_bit     <= 4'd0;
      tx_byte    <= {BYTE_W{1'b0}};
      txd        <= 1'b0;
      if (from_mem) begin
        rd_addr    <= rd_addr + ADDR_W'(1);
        words_left <= words_left - (ADDR_W+1)'(1);
      end
    end else if (in_tx && !tx_on) begin
      fetch_wait <= 1'b0;
    end else if (bit_end) begin
      tx_cyc <= {CYC_W{1'b0}};
      if (word_end) begin
        tx_on    <= 1'b0;
        txd      <= 1'b1;
        hold_cnt <= {HOLD_W{1'b0}};
      end else if (frame_end) begin
        tx_byte <= tx_byte + BYTE_W'(1);
        tx_word <= tx_word >> 4'd8;
        tx_bit  <= 4'd0;
        txd     <= 1'b0;
      end else begin
        tx_bit <= tx_bit + 4'd1;
        txd    <= (tx_bit == 4'd8) ? 1'b1 : tx_word[tx_bit[2:0]];
      end
    end else if (tx_on) begin
      tx_cyc <= tx_cyc + CYC_W'(1);
    end else if (state == S_RELEASE) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  rx_state_t          rx_state, rx_next;
  logic               rxd_q;
  logic [CYC_W-1:0]   rx_cyc;
  logic [2:0]         rx_cnt;
  logic [7:0]         rx_shift;
  logic               rx_half, rx_full, push;

  assign rx_half = (rx_cyc == HALF_LAST);
  assign rx_full = (rx_cyc == BIT_LAST);
  assign push    = (rx_state == R_STOP) && rx_full && rxd;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE: begin
        if ((state == S_RUN) && rxd_q && !rxd) rx_next = R_START;
        else                                   rx_next = R_IDLE;
      end
      R_START: begin
        if (rx_half) rx_next = rxd ? R_IDLE : R_DATA;
        else         rx_next = R_START;
      end
      R_DATA: begin
        if (rx_full && (rx_cnt == 3'd7)) rx_next = R_STOP;
        else                             rx_next = R_DATA;
      end
      R_STOP: begin
        if (rx_full) rx_next = R_IDLE;
        else         rx_next = R_STOP;
      end
      default: rx_next = R_IDLE;
    endcase
  end

  // Receiver: half-bit recheck of the start bit, then full-bit sampling of data and stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= R_IDLE;
      rxd_q     <= 1'b1;
      rx_cyc    <= {CYC_W{1'b0}};
      rx_cnt    <= 3'd0;
      rx_shift  <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rxd_q    <= rxd;
      case (rx_state)
        R_START: rx_cyc <= rx_half ? {CYC_W{1'b0}} : rx_cyc + CYC_W'(1);
        R_DATA: begin
          if (rx_full) begin
            rx_cyc   <= {CYC_W{1'b0}};
            rx_cnt   <= rx_cnt + 3'd1;
            rx_shift <= {rxd, rx_shift[7:1]};
          end else begin
            rx_cyc <= rx_cyc + CYC_W'(1);
          end
        end
        R_STOP: begin
          rx_cyc <= rx_full ? {CYC_W{1'b0}} : rx_cyc + CYC_W'(1);
          if (rx_full && !rxd) frame_err <= 1'b1;
        end
        default: begin
          rx_cyc <= {CYC_W{1'b0}};
          rx_cnt <= 3'd0;
        end
      endcase
    end
  end

  logic [7:0]       fifo_mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   rx_count, after_pop;
  logic             pop, accept;

  // Pop is applied before push, so a full FIFO popped in the same cycle still accepts.
  assign pop       = rx_ready && (|rx_count);
  assign after_pop = rx_count - (PTR_W+1)'(pop);
  assign accept    = push && (after_pop != DEPTH);

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= {PTR_W{1'b0}};
      rd_ptr      <= {PTR_W{1'b0}};
      rx_count    <= {(PTR_W+1){1'b0}};
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      rx_overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      rx_count <= after_pop + (PTR_W+1)'(accept);
      rx_valid <= |(after_pop + (PTR_W+1)'(accept));
      if (push && !accept) rx_overflow <= 1'b1;
      if (|after_pop)  rx_data <= fifo_mem[rd_ptr + PTR_W'(pop)];
      else if (accept) rx_data <= rx_shift;
    end
  end
endmodule

// File: tb/tb_host_link_seq.sv
// Self-checking bench for host_link_seq: expected txd/core_rst waveforms and FIFO contents
// come from a cycle-count model of the link rules and a byte queue.
module tb_host_link_seq;
  localparam int CPH   = 4;
  localparam int DB    = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 16;
  localparam int HOLD  = 3;
  localparam int FRAME = 20*CPH;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, rxd = 1'b1, rx_ready = 1'b0;
  logic [AW:0]   word_count = '0;
  logic [AW-1:0] rd_addr;
  logic [8*DB-1:0] rd_data;
  logic          txd, core_rst, busy, running, rx_valid, rx_overflow, frame_err;
  logic [7:0]    rx_data;
  logic [8*DB-1:0] mem [2**AW];
  int            tests = 0, fails = 0;
  byte unsigned  rxq[$];
  bit            exp_ovf, exp_ferr;

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  host_link_seq #(.CLK_PER_HALF_BIT(CPH), .DATA_BYTES(DB), .ADDR_W(AW),
                  .RX_DEPTH(DEPTH), .RESET_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .rd_addr(rd_addr),
    .rd_data(rd_data), .txd(txd), .rxd(rxd), .core_rst(core_rst), .busy(busy),
    .running(running), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_overflow(rx_overflow), .frame_err(frame_err));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
    rxq = {}; exp_ovf = 1'b0; exp_ferr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1); check("rst_core_rst", core_rst, 1);
    check("rst_busy", busy, 0); check("rst_running", running, 0);
    check("rst_rx_valid", rx_valid, 0); check("rst_rx_data", rx_data, 0);
    check("rst_ovf", rx_overflow, 0); check("rst_ferr", frame_err, 0);
    check("rst_rd_addr", rd_addr, 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Start a load of wc words and check txd/core_rst/busy/running on every cycle.
  task automatic run_load(input int wc, input bit poke);
    byte unsigned s[$];
    logic [7:0] cur;
    int nb, fall, n, bi;
    logic exp_txd;
    s = {};
`ifdef HOST_LINK_LEN_HDR_EN
    for (int i = 0; i < DB; i++) s.push_back(8'(wc >> (8*i)));
`endif
    for (int w = 0; w < wc; w++)
      for (int i = 0; i < DB; i++) s.push_back(mem[w][8*i +: 8]);
    nb   = s.size();
    fall = (nb == 0) ? HOLD : 2 + FRAME*nb + HOLD;
    word_count = (AW+1)'(wc); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < fall + 4; k++) begin
      if (k > 0) @(negedge clk);
      n = k - 2;
      if (k < 2 || n >= FRAME*nb) exp_txd = 1'b1;
      else begin
        cur = s[n / FRAME];
        bi  = (n % FRAME) / (2*CPH);
        exp_txd = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : cur[bi-1];
      end
      check("load_txd", txd, exp_txd);
      check("load_core_rst", core_rst, k < fall);
      check("load_busy", busy, k < fall);
      check("load_running", running, k >= fall);
      start = poke && (k == 50);
    end
    start = 1'b0;
  endtask

  // Drive one 8N1 frame on rxd; optionally pop exactly on the stop-bit sample cycle.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit pop_at_stop, input bit in_run);
    int bi;
    bit was_empty;
    was_empty = (rxq.size() == 0);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (in_run && stop_ok && was_empty && c == 19*CPH)     check("rx_valid_before", rx_valid, 0);
      if (in_run && stop_ok && was_empty && c == 19*CPH + 1) check("rx_valid_rise", rx_valid, 1);
      bi  = c / (2*CPH);
      rxd = (bi == 0) ? 1'b0 : (bi == 9) ? stop_ok : b[bi-1];
      rx_ready = pop_at_stop && (c == 19*CPH);
    end
    if (in_run) begin
      if (pop_at_stop) void'(rxq.pop_front());
      if (!stop_ok) exp_ferr = 1'b1;
      else if (rxq.size() < DEPTH) rxq.push_back(b);
      else exp_ovf = 1'b1;
    end
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_ovf", rx_overflow, exp_ovf);
    check("rx_ferr", frame_err, exp_ferr);
    check("rx_valid", rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) check("rx_head", rx_data, rxq[0]);
  endtask

  task automatic drain();
    while (rxq.size() != 0) begin
      check("pop_valid", rx_valid, 1);
      check("pop_data", rx_data, rxq[0]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(rxq.pop_front());
    end
    check("drain_empty", rx_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = $urandom;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      repeat (100) @(negedge clk);
      check("idle_txd", txd, 1); check("idle_core_rst", core_rst, 1);
      check("idle_busy", busy, 0); check("idle_running", running, 0);
    end
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
    check("rx_off_outside_run", rx_valid, 0);

    mem[0] = 32'h11223344;
    run_load(1, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b1);
    drain();

    rxd = 1'b0; repeat (2) @(negedge clk); rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", frame_err, 0);
    send_byte(8'h5A, 1'b0, 1'b0, 1'b1);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_no_push", rx_valid, 0);

    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < 4; i++) mem[i] = $urandom;
      run_load($urandom_range(1, 3), 1'b1);
      for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b1, 1'b0, 1'b1);
      send_byte(8'($urandom), 1'b1, 1'b1, 1'b1);
      drain();
    end

    do_reset();
    run_load(0, 1'b0);

    do_reset();
    mem[0] = $urandom; mem[1] = $urandom;
    word_count = (AW+1)'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 + FRAME + 1) @(negedge clk);
    check("abort_pre_txd", txd, 0);
    rst = 1'b1;
    #1;
    check("abort_txd", txd, 1); check("abort_core_rst", core_rst, 1);
    check("abort_busy", busy, 0); check("abort_running", running, 0);
    check("abort_rd_addr", rd_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem[0] = $urandom;
    run_load(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/host_link_seq.md
# host_link_seq

Synthesizable host-side link sequencer for the core bring-up path. It holds the core in reset and streams a program image over a UART line at a parametrised bit rate. It then releases the core's reset after a programmable hold and captures bytes the core sends back into a receive FIFO. It sits between a program-image memory and the core wrapper's serial pins, and replaces the fixed two-reset-plus-UART-model bench arrangement with one parametrised block.

## Interface
Parameters:
- CLK_PER_HALF_BIT, 100, clock cycles per half UART bit; one bit time is 2*CLK_PER_HALF_BIT cycles; legal values ≥2.
- DATA_BYTES, 4, bytes per program word, sent LSB byte first; legal range 1–8.
- ADDR_W, 8, program address width; maximum image size is 2^ADDR_W words.
- RX_DEPTH, 16, receive FIFO depth; must be a power of two, ≥2.
- RESET_HOLD, 3, cycles core_rst stays high after the last transmitted stop bit; legal values ≥1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- word_count  in  ADDR_W+1  number of words to send, sampled on start.
- rd_addr  out  ADDR_W  program memory read address.
- rd_data  in  8*DATA_BYTES  memory data, valid one cycle after rd_addr.
- txd  out  1  serial out to core, idle high.
- rxd  in  1  serial in from core, already synchronised.
- core_rst  out  1  active-high reset to the core.
- busy  out  1  high in LOAD or RELEASE.
- running  out  1  high in RUN.
- rx_valid  out  1  receive FIFO not empty.
- rx_data  out  8  FIFO head byte.
- rx_ready  in  1  pops the FIFO when rx_valid is also high.
- rx_overflow  out  1  sticky flag; a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky flag; a byte was received with its stop bit sampled low.

## Operation
- States:
  - IDLE → LOAD on start (HDR, when compiled in, precedes LOAD).
  - LOAD → RELEASE after the last stop bit.
  - RELEASE → RUN after RESET_HOLD cycles.
  - RUN is terminal; only rst leaves it.
- word_count=0: start goes directly to RELEASE (or to HDR when compiled in).
- start outside IDLE is ignored with no side effects.
- TX frame is 8N1: start bit 0, data bits LSB first, stop bit 1.
- Frames are back-to-back: the start bit of the next byte follows the stop bit of the previous one immediately.
- Word k is read at rd_addr=k. Its bytes go out in the order [7:0], [15:8], and so on.
- rd_addr is issued early enough that data is registered before the next word's first start bit, so no gap is ever inserted.
- RX is active only in RUN:
  - Falling edge detected → wait CLK_PER_HALF_BIT cycles → recheck the line. If it is high, treat it as a glitch and return to rx idle.
  - Then sample every 2*CLK_PER_HALF_BIT cycles: 8 data bits, then the stop bit.
  - A stop bit sampled low sets frame_err and discards the byte.
- FIFO:
  - A push while full drops the byte and sets rx_overflow.
  - A push and a pop in the same cycle when full is a pop followed by a push; there is no overflow.
- rst asserted mid-operation aborts everything within the same cycle (asynchronous). Sticky flags clear only on rst.

## Timing
- Reset values:
  - txd=1, core_rst=1.
  - busy=0, running=0, rx_valid=0, rx_data=0.
  - rx_overflow=0, frame_err=0, rd_addr=0.
- First start bit: txd falls 2 cycles after the start pulse (1 cycle to issue rd_addr, 1 cycle for the read).
- Each byte occupies exactly 20*CLK_PER_HALF_BIT cycles on txd.
- core_rst falls exactly RESET_HOLD cycles after the last stop bit ends. running rises in that same cycle.
- Received bytes: rx_valid rises the cycle after the stop-bit sample.
- rx_data is registered and is the FIFO head; it changes the cycle after a pop.

## Configuration
- HOST_LINK_LEN_HDR_EN:
  - Defined: state HDR is inserted before LOAD. It transmits word_count as DATA_BYTES bytes, little-endian, zero-extended. This applies even when word_count=0.
  - Undefined: there is no header, and the payload starts directly.

## Test plan
- Reset, no start: txd=1, core_rst=1, and busy and running stay 0 for 1000 cycles.
- CLK_PER_HALF_BIT=4, word_count=1, mem[0]=0x11223344:
  - txd carries 0x44, 0x33, 0x22, 0x11, each frame 80 cycles, with no gaps.
  - core_rst falls 3 cycles after the final stop bit.
- word_count=0: core_rst falls RESET_HOLD cycles after start, and txd never toggles.
  - With HOST_LINK_LEN_HDR_EN, 4 header bytes of 0x00 are sent first.
- In RUN, drive 20 bytes 0x00..0x13 on rxd with rx_ready=0:
  - The FIFO holds 0x00..0x0F and rx_overflow=1.
  - Popping yields 0x00..0x0F in order.
- In RUN:
  - Drive a byte with its stop bit low: frame_err=1 and nothing is pushed.
  - Drive a 2-cycle low glitch on rxd: nothing is pushed and frame_err is unchanged.
- Assert rst during the second byte of LOAD: txd=1 and core_rst=1 immediately, and the state is IDLE. A new start restarts from rd_addr=0.
